eth_deframer: RTL

//  Receive-side inverse of the Ethernet TX framing path. Takes a byte AXIS stream of raw frames
//  (preamble, SFD, dst MAC, src MAC, ethertype, payload, FCS) from the PHY/MAC RX interface.

---
 rtl/eth_pkg.sv | 36 +++
 rtl/eth_deframer_if.sv | 42 ++++
 rtl/axis_tail_trim.sv | 62 ++++++
 rtl/eth_deframer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module  : eth_pkg
// Brief   : Ethernet RX framing constants, state encoding and CRC-32 helper.
// Revision: 1.0 - initial release
// ============================================================================
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE_BYTE    = 8'h55;
    localparam logic [7:0]  ETH_SFD_BYTE         = 8'hD5;
    localparam int          ETH_MAC_OCTETS       = 6;
    localparam int          ETH_ETHERTYPE_OCTETS = 2;
    localparam int          ETH_FCS_OCTETS       = 4;
    localparam logic [31:0] ETH_CRC_RESIDUE      = 32'hDEBB20E3;
    localparam logic [31:0] ETH_CRC_INIT         = 32'hFFFFFFFF;
    localparam logic [31:0] ETH_CRC_POLY         = 32'hEDB88320;

    typedef enum logic [1:0] {
        ETH_RX_PREAMBLE = 2'd0,
        ETH_RX_HEADER   = 2'd1,
        ETH_RX_PAYLOAD  = 2'd2,
        ETH_RX_DROP     = 2'd3
    } eth_rx_state_t;

    // Reflected CRC-32, one octet, LSB first.
    function automatic logic [31:0] eth_crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_deframer_if.sv
`default_nettype none
// ============================================================================
// Module  : eth_deframer_if
// Brief   : Raw-frame input, payload output and header/status bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface eth_deframer_if;

    logic        in_axis_tready;
    logic        in_axis_tvalid;
    logic        in_axis_tlast;
    logic [7:0]  in_axis_tdata;
    logic        payload_axis_tready;
    logic        payload_axis_tvalid;
    logic        payload_axis_tlast;
    logic        payload_axis_tuser;
    logic [7:0]  payload_axis_tdata;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic        hdr_valid;
    logic        frame_done;
    logic        frame_crc_ok;
    logic        frame_err;

    // master: the deframer itself; slave: the PHY/MAC and IP-stack side.
    modport master (
        input  in_axis_tvalid, in_axis_tlast, in_axis_tdata, payload_axis_tready,
        output in_axis_tready, payload_axis_tvalid, payload_axis_tlast, payload_axis_tuser,
               payload_axis_tdata, dst_mac, src_mac, ethertype, hdr_valid, frame_done,
               frame_crc_ok, frame_err
    );

    modport slave (
        output in_axis_tvalid, in_axis_tlast, in_axis_tdata, payload_axis_tready,
        input  in_axis_tready, payload_axis_tvalid, payload_axis_tlast, payload_axis_tuser,
               payload_axis_tdata, dst_mac, src_mac, ethertype, hdr_valid, frame_done,
               frame_crc_ok, frame_err
    );

endinterface
`default_nettype wire

// File: rtl/axis_tail_trim.sv
`default_nettype none
// ============================================================================
// Module  : axis_tail_trim
// Brief   : Holds back the final N bytes of each AXIS packet; tlast moves to
//           the last kept byte. N must be at least 2.
// Revision: 1.0 - initial release
// ============================================================================
module axis_tail_trim #(
    parameter int N = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_s_tvalid,
    output logic            o_s_tready,
    input  wire logic       i_s_tlast,
    input  wire logic [7:0] i_s_tdata,
    output logic            o_m_tvalid,
    input  wire logic       i_m_tready,
    output logic            o_m_tlast,
    output logic [7:0]      o_m_tdata,
    output logic            o_full
);

    localparam int              c_cw   = $clog2(N + 1);
    localparam logic [c_cw-1:0] c_full = c_cw'(N);

    logic [c_cw-1:0] r_cnt;
    logic [8*N-1:0]  r_buf;
    logic            w_full;
    logic            w_beat;

    assign w_full     = (r_cnt == c_full);
    assign o_s_tready = w_full ? i_m_tready : 1'b1;
    assign w_beat     = i_s_tvalid & o_s_tready;
    assign o_m_tvalid = i_s_tvalid & w_full;
    assign o_m_tlast  = i_s_tlast;
    assign o_m_tdata  = r_buf[8*N-1 -: 8];
    assign o_full     = w_full;

    // The tail left in the line at tlast is the trimmed part; just forget it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_beat) begin
            if (i_s_tlast) begin
                r_cnt <= '0;
            end else if (!w_full) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf <= '0;
        end else if (w_beat) begin
            r_buf <= {r_buf[8*N-9:0], i_s_tdata};
        end
    end

endmodule
`default_nettype wire

// File: rtl/eth_deframer.sv
`default_nettype none
// ============================================================================
// Module  : eth_deframer
// Brief   : Strips preamble/SFD, captures the MAC header, streams the payload
//           without FCS and flags the CRC-32 result on the last payload beat.
// Revision: 1.0 - initial release
// ============================================================================
module eth_deframer
    import eth_pkg::*;
#(
    parameter int MIN_PREAMBLE = 1
) (
    input wire logic       clk,
    input wire logic       sreset,
    eth_deframer_if.master bus
);

    localparam logic [1:0] c_st_preamble = ETH_RX_PREAMBLE;
    localparam logic [1:0] c_st_header   = ETH_RX_HEADER;
    localparam logic [1:0] c_st_payload  = ETH_RX_PAYLOAD;
    localparam logic [1:0] c_st_drop     = ETH_RX_DROP;

    localparam logic [3:0] c_hdr_src  = 4'(ETH_MAC_OCTETS);
    localparam logic [3:0] c_hdr_type = 4'(2 * ETH_MAC_OCTETS);
    localparam logic [3:0] c_hdr_last = 4'(2 * ETH_MAC_OCTETS + ETH_ETHERTYPE_OCTETS - 1);

    logic [1:0]  r_state;
    logic [2:0]  r_pre_cnt;
    logic [3:0]  r_hdr_cnt;
    logic [31:0] r_crc;
    logic [47:0] r_sh_dst;
    logic [47:0] r_sh_src;
    logic [7:0]  r_sh_type_hi;
    logic [47:0] r_dst;
    logic [47:0] r_src;
    logic [15:0] r_type;
    logic        r_hdr_valid;
    logic        r_frame_done;
    logic        r_frame_crc_ok;
    logic        r_frame_err;

    logic        w_in_payload;
    logic        w_in_ready;
    logic        w_in_beat;
    logic [31:0] w_crc_next;
    logic        w_crc_good;
    logic        w_pre_ok;
    logic        w_trim_s_ready;
    logic        w_trim_full;
    logic [7:0]  w_d;

    assign w_d          = bus.in_axis_tdata;
    assign w_in_payload = (r_state == c_st_payload);
    assign w_in_ready   = w_in_payload ? w_trim_s_ready : 1'b1;
    assign w_in_beat    = bus.in_axis_tvalid & w_in_ready;
    assign w_crc_next   = eth_crc32_byte(r_crc, w_d);
    assign w_crc_good   = (w_crc_next == ETH_CRC_RESIDUE);
    assign w_pre_ok     = (int'(r_pre_cnt) >= MIN_PREAMBLE);

    axis_tail_trim #(
        .N (ETH_FCS_OCTETS)
    ) u_trim (
        .clk        (clk),
        .rst        (sreset),
        .i_s_tvalid (bus.in_axis_tvalid & w_in_payload),
        .o_s_tready (w_trim_s_ready),
        .i_s_tlast  (bus.in_axis_tlast),
        .i_s_tdata  (w_d),
        .o_m_tvalid (bus.payload_axis_tvalid),
        .i_m_tready (bus.payload_axis_tready),
        .o_m_tlast  (bus.payload_axis_tlast),
        .o_m_tdata  (bus.payload_axis_tdata),
        .o_full     (w_trim_full)
    );

    assign bus.in_axis_tready     = w_in_ready;
    assign bus.payload_axis_tuser = ~w_crc_good;
    assign bus.dst_mac            = r_dst;
    assign bus.src_mac            = r_src;
    assign bus.ethertype          = r_type;
    assign bus.hdr_valid          = r_hdr_valid;
    assign bus.frame_done         = r_frame_done;
    assign bus.frame_crc_ok       = r_frame_crc_ok;
    assign bus.frame_err          = r_frame_err;

    always_ff @(posedge clk) begin
        if (sreset) begin
            r_state        <= c_st_preamble;
            r_pre_cnt      <= '0;
            r_hdr_cnt      <= '0;
            r_crc          <= ETH_CRC_INIT;
            r_sh_dst       <= '0;
            r_sh_src       <= '0;
            r_sh_type_hi   <= '0;
            r_dst          <= '0;
            r_src          <= '0;
            r_type         <= '0;
            r_hdr_valid    <= 1'b0;
            r_frame_done   <= 1'b0;
            r_frame_crc_ok <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_hdr_valid    <= 1'b0;
            r_frame_done   <= 1'b0;
            r_frame_crc_ok <= 1'b0;
            r_frame_err    <= 1'b0;
            if (w_in_beat) begin
                case (r_state)
                    c_st_preamble: begin
                        r_crc     <= ETH_CRC_INIT;
                        r_hdr_cnt <= '0;
                        if (bus.in_axis_tlast) begin
                            r_frame_done <= 1'b1;
                            r_frame_err  <= 1'b1;
                            r_pre_cnt    <= '0;
                        end else if (w_d == ETH_PREAMBLE_BYTE) begin
                            if (r_pre_cnt != 3'd7) begin
                                r_pre_cnt <= r_pre_cnt + 3'd1;
                            end
                        end else if (w_d == ETH_SFD_BYTE && w_pre_ok) begin
                            r_state   <= c_st_header;
                            r_pre_cnt <= '0;
                        end else begin
                            r_state   <= c_st_drop;
                            r_pre_cnt <= '0;
                        end
                    end
                    c_st_header: begin
                        r_crc     <= w_crc_next;
                        r_hdr_cnt <= r_hdr_cnt + 4'd1;
                        if (bus.in_axis_tlast) begin
                            r_state      <= c_st_preamble;
                            r_crc        <= ETH_CRC_INIT;
                            r_frame_done <= 1'b1;
                            r_frame_err  <= 1'b1;
                        end else if (r_hdr_cnt < c_hdr_src) begin
                            r_sh_dst <= {r_sh_dst[39:0], w_d};
                        end else if (r_hdr_cnt < c_hdr_type) begin
                            r_sh_src <= {r_sh_src[39:0], w_d};
                        end else if (r_hdr_cnt != c_hdr_last) begin
                            r_sh_type_hi <= w_d;
                        end else begin
                            // Commit all fields at once so a runt header never disturbs them.
                            r_dst       <= r_sh_dst;
                            r_src       <= r_sh_src;
                            r_type      <= {r_sh_type_hi, w_d};
                            r_hdr_valid <= 1'b1;
                            r_state     <= c_st_payload;
                        end
                    end
                    c_st_payload: begin
                        r_crc <= w_crc_next;
                        if (bus.in_axis_tlast) begin
                            r_state        <= c_st_preamble;
                            r_crc          <= ETH_CRC_INIT;
                            r_frame_done   <= 1'b1;
                            r_frame_crc_ok <= w_trim_full & w_crc_good;
                            r_frame_err    <= ~w_trim_full;
                        end
                    end
                    default: begin
                        if (bus.in_axis_tlast) begin
                            r_state      <= c_st_preamble;
                            r_frame_done <= 1'b1;
                            r_frame_err  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
